// File: rtl/measure_epoch_sched.sv
// Epoch scheduler for the ping-pong measurement counter banks: times epochs, flips the active
// bank, and hands the retired bank to the readout engine once in-flight updates have drained.
module measure_epoch_sched #(
    parameter int unsigned C_TIMER_WIDTH    = 32,
    parameter int unsigned C_EPOCH_ID_WIDTH = 16,
    parameter int unsigned C_OVR_WIDTH      = 16,
    parameter int unsigned GUARD_CYCLES     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_enable,
    input  logic [C_TIMER_WIDTH-1:0]    in_epoch_len,
    input  logic                        in_update_busy,
    input  logic                        in_read_done_1,
    input  logic                        in_read_done_2,
    output logic                        out_active_bank,
    output logic                        out_ready_read_1,
    output logic                        out_ready_read_2,
    output logic                        out_epoch_tick,
    output logic [C_EPOCH_ID_WIDTH-1:0] out_epoch_id,
    output logic [C_OVR_WIDTH-1:0]      out_overrun_cnt,
    output logic                        out_running
);

    localparam int unsigned GuardW = (GUARD_CYCLES < 1) ? 1 : $clog2(GUARD_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StRun, StGuard, StRead} state_e;

    state_e                      state_q, state_d;
    logic [C_TIMER_WIDTH-1:0]    timer_q, timer_d;
    logic [C_TIMER_WIDTH-1:0]    len_q, len_d;
    logic [GuardW-1:0]           guard_q, guard_d;
    logic                        stop_q, stop_d;
    logic                        active_q, active_d;
    logic                        rdy1_q, rdy1_d;
    logic                        rdy2_q, rdy2_d;
    logic                        tick_q, tick_d;
    logic [C_EPOCH_ID_WIDTH-1:0] id_q, id_d;
    logic [C_OVR_WIDTH-1:0]      ovr_q, ovr_d;

    logic                     expire;
    logic                     flip;
    logic                     overrun;
    logic                     done_match;
    logic                     guard_done;
    logic [C_TIMER_WIDTH-1:0] len_sample;

    assign expire     = (timer_q == len_q - C_TIMER_WIDTH'(1));
    assign len_sample = (in_epoch_len < C_TIMER_WIDTH'(2)) ? C_TIMER_WIDTH'(2) : in_epoch_len;
    // The retired bank is always the one not counting, so the done pulse is picked by active_q.
    assign done_match = active_q ? in_read_done_1 : in_read_done_2;
    assign guard_done = (guard_q >= GuardW'(GUARD_CYCLES)) && !in_update_busy;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        len_d   = len_q;
        guard_d = guard_q;
        stop_d  = stop_q;
        active_d = active_q;
        rdy1_d  = rdy1_q;
        rdy2_d  = rdy2_q;
        id_d    = id_q;
        ovr_d   = ovr_q;
        flip    = 1'b0;
        overrun = 1'b0;

        if (state_q != StIdle) begin
            timer_d = timer_q + C_TIMER_WIDTH'(1);
        end

        case (state_q)
            StIdle: begin
                timer_d = '0;
                if (in_enable) begin
                    state_d = StRun;
                    len_d   = len_sample;
                end
            end
            StRun: begin
                if (expire) begin
                    flip    = 1'b1;
                    state_d = StGuard;
                end else if (!in_enable) begin
                    flip    = 1'b1;
                    stop_d  = 1'b1;
                    state_d = StGuard;
                end
            end
            StGuard: begin
                if (!in_enable) begin
                    stop_d = 1'b1;
                end
                if (guard_q < GuardW'(GUARD_CYCLES)) begin
                    guard_d = guard_q + GuardW'(1);
                end
                overrun = expire;
                if (guard_done) begin
                    state_d = StRead;
                    rdy1_d  = active_q;
                    rdy2_d  = !active_q;
                end
            end
            StRead: begin
                if (!in_enable) begin
                    stop_d = 1'b1;
                end
                if (done_match) begin
                    rdy1_d = 1'b0;
                    rdy2_d = 1'b0;
                    if (stop_q || !in_enable) begin
                        state_d = StIdle;
                        stop_d  = 1'b0;
                    end else if (expire) begin
                        flip    = 1'b1;
                        state_d = StGuard;
                    end else begin
                        state_d = StRun;
                    end
                end else begin
                    // Readout is late: stretch the epoch instead of flipping onto an uncleared bank.
                    overrun = expire;
                end
            end
            default: state_d = StIdle;
        endcase

        if (flip) begin
            active_d = !active_q;
            id_d     = id_q + C_EPOCH_ID_WIDTH'(1);
            len_d    = len_sample;
            guard_d  = '0;
        end
        if (flip || (expire && state_q != StIdle)) begin
            timer_d = '0;
        end
        if (overrun && (ovr_q != {C_OVR_WIDTH{1'b1}})) begin
            ovr_d = ovr_q + C_OVR_WIDTH'(1);
        end
    end

    assign tick_d = flip;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            len_q    <= '0;
            guard_q  <= '0;
            stop_q   <= 1'b0;
            active_q <= 1'b0;
            rdy1_q   <= 1'b0;
            rdy2_q   <= 1'b0;
            tick_q   <= 1'b0;
            id_q     <= '0;
            ovr_q    <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            len_q    <= len_d;
            guard_q  <= guard_d;
            stop_q   <= stop_d;
            active_q <= active_d;
            rdy1_q   <= rdy1_d;
            rdy2_q   <= rdy2_d;
            tick_q   <= tick_d;
            id_q     <= id_d;
            ovr_q    <= ovr_d;
        end
    end

    assign out_active_bank  = active_q;
    assign out_ready_read_1 = rdy1_q;
    assign out_ready_read_2 = rdy2_q;
    assign out_epoch_tick   = tick_q;
    assign out_epoch_id     = id_q;
    assign out_overrun_cnt  = ovr_q;
    assign out_running      = (state_q != StIdle);

endmodule

// File: tb/tb_measure_epoch_sched.sv
// Directed bench for measure_epoch_sched; epoch id is built 4 bits wide so its wrap is reachable.
module tb_measure_epoch_sched;

    localparam int unsigned IdW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic [31:0]    epoch_len;
    logic           busy;
    logic           done1;
    logic           done2;
    logic           active;
    logic           ready1;
    logic           ready2;
    logic           tick;
    logic [IdW-1:0] epoch_id;
    logic [15:0]    ovr;
    logic           running;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    measure_epoch_sched #(
        .C_EPOCH_ID_WIDTH(IdW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_enable       (enable),
        .in_epoch_len    (epoch_len),
        .in_update_busy  (busy),
        .in_read_done_1  (done1),
        .in_read_done_2  (done2),
        .out_active_bank (active),
        .out_ready_read_1(ready1),
        .out_ready_read_2(ready2),
        .out_epoch_tick  (tick),
        .out_epoch_id    (epoch_id),
        .out_overrun_cnt (ovr),
        .out_running     (running)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        enable = 1'b0;
        busy   = 1'b0;
        done1  = 1'b0;
        done2  = 1'b0;
        step_n(2);
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_active"}, active, 0);
        check({tag, "_rdy1"}, ready1, 0);
        check({tag, "_rdy2"}, ready2, 0);
        check({tag, "_tick"}, tick, 0);
        check({tag, "_id"}, epoch_id, 0);
        check({tag, "_ovr"}, ovr, 0);
        check({tag, "_running"}, running, 0);
    endtask

    int ticks;
    int viol;

    initial begin
        epoch_len = 32'd10;
        do_reset();
        check_all_zero("reset");

        // Basic epoch: flip 10 cycles into RUN, ready after guard, cleared by done_1.
        enable = 1'b1;
        step();                                   // E1
        check("s1_running", running, 1);
        step_n(9);                                // E10
        check("s1_pre_flip_active", active, 0);
        check("s1_pre_flip_tick", tick, 0);
        step();                                   // E11
        check("s1_flip_active", active, 1);
        check("s1_flip_tick", tick, 1);
        check("s1_flip_id", epoch_id, 1);
        step();
        check("s1_tick_pulse", tick, 0);
        step_n(3);                                // E15
        check("s1_guard_rdy1", ready1, 0);
        step();                                   // E16
        check("s1_rdy1", ready1, 1);
        check("s1_rdy2", ready2, 0);
        step_n(2);                                // E18
        done1 = 1'b1;
        step();                                   // E19
        done1 = 1'b0;
        check("s1_rdy1_clear", ready1, 0);
        step();                                   // E20
        check("s1_active_hold", active, 1);
        step();                                   // E21
        check("s1_flip2_active", active, 0);
        check("s1_flip2_id", epoch_id, 2);

        // Busy held after flip: ready waits; guard expiry counts an overrun.
        do_reset();
        epoch_len = 32'd10;
        enable    = 1'b1;
        step_n(11);                               // E11
        busy = 1'b1;
        step_n(5);                                // E16
        check("s2_busy_rdy1_e16", ready1, 0);
        step_n(4);                                // E20
        busy = 1'b0;
        check("s2_busy_rdy1_e20", ready1, 0);
        step();                                   // E21
        check("s2_rdy1", ready1, 1);
        check("s2_ovr", ovr, 1);
        check("s2_active", active, 1);

        // Late readout: two overruns, flip at first RUN expiry after done_1.
        do_reset();
        epoch_len = 32'd10;
        enable    = 1'b1;
        step_n(36);                               // E36
        check("s3_ovr", ovr, 2);
        check("s3_rdy1", ready1, 1);
        check("s3_active", active, 1);
        check("s3_id", epoch_id, 1);
        done1 = 1'b1;
        step();                                   // E37
        done1 = 1'b0;
        check("s3_rdy1_clear", ready1, 0);
        step_n(3);                                // E40
        check("s3_active_hold", active, 1);
        step();                                   // E41
        check("s3_flip_active", active, 0);
        check("s3_flip_id", epoch_id, 2);
        check("s3_ovr_after", ovr, 2);
        step_n(4);                                // E45
        check("s3_rdy2_guard", ready2, 0);
        step();                                   // E46
        check("s3_rdy2", ready2, 1);
        check("s3_rdy1_off", ready1, 0);

        // done_1 coincident with expiry in READ: immediate flip, no overrun.
        do_reset();
        epoch_len = 32'd10;
        enable    = 1'b1;
        step_n(20);                               // E20
        check("s4_rdy1", ready1, 1);
        done1 = 1'b1;
        step();                                   // E21
        done1 = 1'b0;
        check("s4_active", active, 0);
        check("s4_id", epoch_id, 2);
        check("s4_tick", tick, 1);
        check("s4_rdy1_clear", ready1, 0);
        check("s4_ovr", ovr, 0);
        step_n(4);                                // E25
        check("s4_rdy2_guard", ready2, 0);
        step();                                   // E26
        check("s4_rdy2", ready2, 1);

        // Enable dropped mid-epoch: final flush, readout, back to idle; done_2 ignored.
        do_reset();
        epoch_len = 32'd10;
        enable    = 1'b1;
        step_n(4);                                // E4
        enable = 1'b0;
        step();                                   // E5
        check("s5_flush_active", active, 1);
        check("s5_flush_tick", tick, 1);
        check("s5_flush_id", epoch_id, 1);
        step_n(4);                                // E9
        check("s5_rdy1_guard", ready1, 0);
        step();                                   // E10
        check("s5_rdy1", ready1, 1);
        done2 = 1'b1;
        step();                                   // E11
        done2 = 1'b0;
        check("s5_done2_ignored", ready1, 1);
        check("s5_running", running, 1);
        done1 = 1'b1;
        step();                                   // E12
        done1 = 1'b0;
        check("s5_rdy1_clear", ready1, 0);
        check("s5_idle", running, 0);
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tick) ticks++;
        end
        check("s5_no_ticks", ticks, 0);
        check("s5_id_hold", epoch_id, 1);

        // Short lengths clamp to 2; then reset while ready_read_2 is high.
        do_reset();
        epoch_len = 32'd0;
        enable    = 1'b1;
        step_n(2);                                // E2
        check("s6_pre_flip", active, 0);
        epoch_len = 32'd1;
        step();                                   // E3
        check("s6_len0_flip", active, 1);
        check("s6_len0_id", epoch_id, 1);
        step_n(2);                                // E5
        check("s6_guard_ovr", ovr, 1);
        step_n(4);                                // E9
        check("s6_rdy1", ready1, 1);
        check("s6_read_ovr", ovr, 3);
        done1 = 1'b1;
        step();                                   // E10
        done1 = 1'b0;
        check("s6_rdy1_clear", ready1, 0);
        step();                                   // E11
        check("s6_len1_flip", active, 0);
        check("s6_len1_id", epoch_id, 2);
        step_n(5);                                // E16
        check("s6_rdy2", ready2, 1);
        check("s6_ovr", ovr, 5);
        rst = 1'b1;
        step();                                   // E17
        check_all_zero("s6_rst");
        rst = 1'b0;

        // Epoch id wrap on the 4-bit build, with exclusion monitored throughout.
        do_reset();
        epoch_len = 32'd2;
        enable    = 1'b1;
        ticks     = 0;
        viol      = 0;
        for (int c = 0; c < 600 && ticks < 16; c++) begin
            done1 = ready1;
            done2 = ready2;
            step();
            done1 = 1'b0;
            done2 = 1'b0;
            if ((ready1 && ready2) || (ready1 && !active) || (ready2 && active)) viol++;
            if (tick) begin
                ticks++;
                check("id_wrap", epoch_id, ticks % 16);
            end
        end
        check("wrap_ticks", ticks, 16);
        check("ready_exclusion", viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
